// File: rtl/cpu_io_port.sv
// -----------------------------------------------------------------------------
// cpu_io_port
//   Host-side I/O responder for the CPU's port pair.
//   - Input path: the host queues INR_W-bit words into a small FIFO. The head
//     word is presented on a registered `inr`/`inr_valid` pair. Each
//     `cpu_in_strobe` consumes the presented word.
//   - Output path: `outvalue` is sampled every cycle into `prev_out`. Any
//     cycle where it differs from the previous sample pushes the new value
//     into an output FIFO. The host drains that FIFO with valid/ready.
//   - Status: sticky underflow and overflow flags, plus a saturating drop
//     counter. A set event takes priority over `clear_status`.
//
// Ports
//   clock, reset          system clock; asynchronous active-low reset
//   host_in_data/valid    host word offered for the CPU
//   host_in_ready         input FIFO not full
//   inr, inr_valid        word presented to the CPU; valid while unconsumed
//   cpu_in_strobe         CPU consumed `inr` (one-cycle pulse)
//   outvalue              CPU output value (watched for changes)
//   host_out_data/valid   oldest captured output value; FIFO not empty
//   host_out_ready        host accepts `host_out_data`
//   clear_status          clears in_underflow, out_overflow, drop_count
//   in_underflow          sticky: strobe seen with no valid `inr`
//   out_overflow          sticky: a change was dropped on a full FIFO
//   drop_count            number of dropped changes, saturating at 255
// -----------------------------------------------------------------------------
module cpu_io_port #(
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 8,
  parameter int INR_W     = 4,
  parameter int OUT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [INR_W-1:0] host_in_data,
  input  logic             host_in_valid,
  output logic             host_in_ready,
  output logic [INR_W-1:0] inr,
  output logic             inr_valid,
  input  logic             cpu_in_strobe,
  input  logic [OUT_W-1:0] outvalue,
  output logic [OUT_W-1:0] host_out_data,
  output logic             host_out_valid,
  input  logic             host_out_ready,
  input  logic             clear_status,
  output logic             in_underflow,
  output logic             out_overflow,
  output logic [7:0]       drop_count
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [INR_W-1:0] r_in_mem [IN_DEPTH];
  logic [IAW:0]     r_in_wr;
  logic [IAW:0]     r_in_rd;
  logic [INR_W-1:0] r_inr;
  logic             r_inr_valid;

  logic             w_in_full;
  logic             w_in_push;
  logic             w_in_pop;
  logic [IAW:0]     w_in_count;
  logic [IAW:0]     w_in_left;
  logic [IAW:0]     w_in_rd_nxt;
  logic             w_inr_valid_nxt;

  assign w_in_full   = (r_in_wr[IAW] != r_in_rd[IAW]) &&
                       (r_in_wr[IAW-1:0] == r_in_rd[IAW-1:0]);
  assign w_in_push   = host_in_valid && !w_in_full;
  assign w_in_pop    = cpu_in_strobe && r_inr_valid;
  assign w_in_count  = r_in_wr - r_in_rd;
  assign w_in_rd_nxt = r_in_rd + (IAW+1)'(w_in_pop);
  // Only entries already stored before this edge count toward the next
  // presented word; a word pushed this cycle becomes visible one edge later.
  assign w_in_left       = w_in_count - (IAW+1)'(w_in_pop);
  assign w_inr_valid_nxt = (w_in_left != '0);

  always_ff @(posedge clock) begin
    if (w_in_push) begin
      r_in_mem[r_in_wr[IAW-1:0]] <= host_in_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_in_wr     <= '0;
      r_in_rd     <= '0;
      r_inr       <= '0;
      r_inr_valid <= 1'b0;
    end else begin
      if (w_in_push) begin
        r_in_wr <= r_in_wr + 1'b1;
      end
      r_in_rd     <= w_in_rd_nxt;
      r_inr_valid <= w_inr_valid_nxt;
      // When nothing remains, hold the last presented value.
      if (w_inr_valid_nxt) begin
        r_inr <= r_in_mem[w_in_rd_nxt[IAW-1:0]];
      end
    end
  end

  assign host_in_ready = !w_in_full;
  assign inr           = r_inr;
  assign inr_valid     = r_inr_valid;

  // ---------------------------------------------------------------------------
  // Output change capture and FIFO
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] r_out_mem [OUT_DEPTH];
  logic [OAW:0]     r_out_wr;
  logic [OAW:0]     r_out_rd;
  logic [OUT_W-1:0] r_prev_out;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_valid;

  logic             w_change;
  logic             w_out_full;
  logic             w_out_pop;
  logic             w_out_push;
  logic             w_drop;
  logic [OAW:0]     w_out_count;
  logic [OAW:0]     w_out_left;
  logic [OAW:0]     w_out_rd_nxt;
  logic             w_out_valid_nxt;

  assign w_change     = (outvalue != r_prev_out);
  assign w_out_full   = (r_out_wr[OAW] != r_out_rd[OAW]) &&
                        (r_out_wr[OAW-1:0] == r_out_rd[OAW-1:0]);
  assign w_out_pop    = r_out_valid && host_out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_out_push   = w_change && (!w_out_full || w_out_pop);
  assign w_drop       = w_change && w_out_full && !w_out_pop;
  assign w_out_count  = r_out_wr - r_out_rd;
  assign w_out_rd_nxt = r_out_rd + (OAW+1)'(w_out_pop);
  assign w_out_left      = w_out_count - (OAW+1)'(w_out_pop);
  assign w_out_valid_nxt = (w_out_left != '0);

  always_ff @(posedge clock) begin
    if (w_out_push) begin
      r_out_mem[r_out_wr[OAW-1:0]] <= outvalue;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_wr    <= '0;
      r_out_rd    <= '0;
      r_prev_out  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_prev_out <= outvalue;
      if (w_out_push) begin
        r_out_wr <= r_out_wr + 1'b1;
      end
      r_out_rd    <= w_out_rd_nxt;
      r_out_valid <= w_out_valid_nxt;
      if (w_out_valid_nxt) begin
        r_out_data <= r_out_mem[w_out_rd_nxt[OAW-1:0]];
      end
    end
  end

  assign host_out_data  = r_out_data;
  assign host_out_valid = r_out_valid;

  // ---------------------------------------------------------------------------
  // Status: set events win over clear_status
  // ---------------------------------------------------------------------------
  logic       r_in_underflow;
  logic       r_out_overflow;
  logic [7:0] r_drop_count;
  logic       w_underflow_evt;

  assign w_underflow_evt = cpu_in_strobe && !r_inr_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_in_underflow <= 1'b0;
      r_out_overflow <= 1'b0;
      r_drop_count   <= '0;
    end else begin
      if (w_underflow_evt) begin
        r_in_underflow <= 1'b1;
      end else if (clear_status) begin
        r_in_underflow <= 1'b0;
      end

      if (w_drop) begin
        r_out_overflow <= 1'b1;
      end else if (clear_status) begin
        r_out_overflow <= 1'b0;
      end

      if (w_drop) begin
        if (clear_status) begin
          r_drop_count <= 8'd1;
        end else if (r_drop_count != 8'hFF) begin
          r_drop_count <= r_drop_count + 8'd1;
        end
      end else if (clear_status) begin
        r_drop_count <= '0;
      end
    end
  end

  assign in_underflow = r_in_underflow;
  assign out_overflow = r_out_overflow;
  assign drop_count   = r_drop_count;

endmodule

// File: tb/tb_cpu_io_port.sv
module tb_cpu_io_port;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  host_in_data;
  logic        host_in_valid;
  logic        host_in_ready;
  logic [3:0]  inr;
  logic        inr_valid;
  logic        cpu_in_strobe;
  logic [15:0] outvalue;
  logic [15:0] host_out_data;
  logic        host_out_valid;
  logic        host_out_ready;
  logic        clear_status;
  logic        in_underflow;
  logic        out_overflow;
  logic [7:0]  drop_count;

  cpu_io_port #(
    .IN_DEPTH (4),
    .OUT_DEPTH(8),
    .INR_W    (4),
    .OUT_W    (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .host_in_data  (host_in_data),
    .host_in_valid (host_in_valid),
    .host_in_ready (host_in_ready),
    .inr           (inr),
    .inr_valid     (inr_valid),
    .cpu_in_strobe (cpu_in_strobe),
    .outvalue      (outvalue),
    .host_out_data (host_out_data),
    .host_out_valid(host_out_valid),
    .host_out_ready(host_out_ready),
    .clear_status  (clear_status),
    .in_underflow  (in_underflow),
    .out_overflow  (out_overflow),
    .drop_count    (drop_count)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Input-path vector: inputs for one cycle, expected outputs after its edge.
  typedef struct packed {
    logic       iv;
    logic [3:0] id;
    logic       stb;
    logic       clr;
    logic [3:0] e_inr;
    logic       e_iv;
    logic       e_rdy;
    logic       e_ud;
  } in_vec_t;

  in_vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // iv id stb clr | inr iv rdy ud
    tbl[0]  = '{1'b1, 4'd10, 1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 4'd11, 1'b0, 1'b0, 4'd10, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 4'd12, 1'b0, 1'b0, 4'd10, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 4'd13, 1'b0, 1'b0, 4'd10, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 4'd9,  1'b0, 1'b0, 4'd10, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd11, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd12, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd13, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd13, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd13, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 4'd0,  1'b0, 1'b1, 4'd13, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 4'd7,  1'b1, 1'b0, 4'd13, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 4'd0,  1'b0, 1'b1, 4'd7,  1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 4'd3,  1'b1, 1'b0, 4'd7,  1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 4'd0,  1'b0, 1'b0, 4'd3,  1'b1, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 4'd0,  1'b1, 1'b0, 4'd3,  1'b0, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 4'd0,  1'b1, 1'b1, 4'd3,  1'b0, 1'b1, 1'b1};
    tbl[17] = '{1'b0, 4'd0,  1'b0, 1'b1, 4'd3,  1'b0, 1'b1, 1'b0};

    reset          = 1'b0;
    host_in_data   = '0;
    host_in_valid  = 1'b0;
    cpu_in_strobe  = 1'b0;
    outvalue       = '0;
    host_out_ready = 1'b0;
    clear_status   = 1'b0;

    repeat (2) step();
    chk("rst_inr",        32'(inr),            32'd0);
    chk("rst_inr_valid",  32'(inr_valid),      32'd0);
    chk("rst_in_ready",   32'(host_in_ready),  32'd1);
    chk("rst_out_valid",  32'(host_out_valid), 32'd0);
    chk("rst_out_data",   32'(host_out_data),  32'd0);
    chk("rst_underflow",  32'(in_underflow),   32'd0);
    chk("rst_overflow",   32'(out_overflow),   32'd0);
    chk("rst_drop_count", 32'(drop_count),     32'd0);
    reset = 1'b1;
    step();

    // ---------------- input path table ----------------
    for (int i = 0; i < 18; i++) begin
      host_in_valid = tbl[i].iv;
      host_in_data  = tbl[i].id;
      cpu_in_strobe = tbl[i].stb;
      clear_status  = tbl[i].clr;
      step();
      chk($sformatf("in%0d_inr", i),   32'(inr),           32'(tbl[i].e_inr));
      chk($sformatf("in%0d_iv", i),    32'(inr_valid),     32'(tbl[i].e_iv));
      chk($sformatf("in%0d_rdy", i),   32'(host_in_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("in%0d_ud", i),    32'(in_underflow),  32'(tbl[i].e_ud));
    end
    host_in_valid = 1'b0;
    cpu_in_strobe = 1'b0;
    clear_status  = 1'b0;

    // ---------------- change capture 0,5,5,9,9,0 ----------------
    outvalue = 16'd0; step();
    chk("cap_none", 32'(host_out_valid), 32'd0);
    outvalue = 16'd5; step();
    chk("cap_lat0", 32'(host_out_valid), 32'd0);
    outvalue = 16'd5; step();
    chk("cap_lat1_v", 32'(host_out_valid), 32'd1);
    chk("cap_lat1_d", 32'(host_out_data),  32'd5);
    outvalue = 16'd9; step();
    outvalue = 16'd9; step();
    outvalue = 16'd0; step();
    step(); step();
    host_out_ready = 1'b1;
    begin
      logic [15:0] exp_cap [3];
      exp_cap[0] = 16'd5; exp_cap[1] = 16'd9; exp_cap[2] = 16'd0;
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("cap%0d_v", i), 32'(host_out_valid), 32'd1);
        chk($sformatf("cap%0d_d", i), 32'(host_out_data),  32'(exp_cap[i]));
        step();
      end
    end
    host_out_ready = 1'b0;
    chk("cap_empty", 32'(host_out_valid), 32'd0);

    // ---------------- overflow: 10 changes, ready low ----------------
    for (int i = 1; i <= 10; i++) begin
      outvalue = 16'(i);
      step();
    end
    step();
    chk("ovf_flag",  32'(out_overflow), 32'd1);
    chk("ovf_drops", 32'(drop_count),   32'd2);
    host_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("ovf%0d_v", i), 32'(host_out_valid), 32'd1);
      chk($sformatf("ovf%0d_d", i), 32'(host_out_data),  32'(i));
      step();
    end
    host_out_ready = 1'b0;
    chk("ovf_empty", 32'(host_out_valid), 32'd0);
    clear_status = 1'b1; step(); clear_status = 1'b0;
    chk("clr_flag",  32'(out_overflow), 32'd0);
    chk("clr_drops", 32'(drop_count),   32'd0);

    // ---------------- full FIFO, change coincides with pop ----------------
    for (int i = 21; i <= 28; i++) begin
      outvalue = 16'(i);
      step();
    end
    step();
    outvalue = 16'd29;
    host_out_ready = 1'b1;
    step();
    host_out_ready = 1'b0;
    step();
    chk("cpop_drops", 32'(drop_count),   32'd0);
    chk("cpop_flag",  32'(out_overflow), 32'd0);
    host_out_ready = 1'b1;
    for (int i = 22; i <= 29; i++) begin
      chk($sformatf("cpop%0d_d", i), 32'(host_out_data), 32'(i));
      step();
    end
    host_out_ready = 1'b0;
    chk("cpop_empty", 32'(host_out_valid), 32'd0);

    // ---------------- drop coinciding with clear: set wins ----------------
    for (int i = 31; i <= 38; i++) begin
      outvalue = 16'(i);
      step();
    end
    outvalue = 16'd39;
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    chk("swin_drops", 32'(drop_count),   32'd1);
    chk("swin_flag",  32'(out_overflow), 32'd1);
    host_out_ready = 1'b1;
    repeat (9) step();
    host_out_ready = 1'b0;
    chk("swin_empty", 32'(host_out_valid), 32'd0);

    // ---------------- asynchronous reset mid-stream ----------------
    host_in_valid = 1'b1; host_in_data = 4'd1; outvalue = 16'd40; step();
    host_in_data = 4'd2;  outvalue = 16'd41; step();
    host_in_valid = 1'b0; step();
    cpu_in_strobe = 1'b0;
    chk("pre_rst_iv", 32'(inr_valid),      32'd1);
    chk("pre_rst_ov", 32'(host_out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_inr",   32'(inr),            32'd0);
    chk("arst_iv",    32'(inr_valid),      32'd0);
    chk("arst_rdy",   32'(host_in_ready),  32'd1);
    chk("arst_ov",    32'(host_out_valid), 32'd0);
    chk("arst_od",    32'(host_out_data),  32'd0);
    chk("arst_ovf",   32'(out_overflow),   32'd0);
    chk("arst_drops", 32'(drop_count),     32'd0);
    outvalue = 16'd0;
    step();
    reset = 1'b1;
    repeat (3) step();
    chk("post_rst_ov",  32'(host_out_valid), 32'd0);
    chk("post_rst_iv",  32'(inr_valid),      32'd0);
    chk("post_rst_rdy", 32'(host_in_ready),  32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_io_port.md
Name: cpu_io_port

Overview:
- Host-side I/O responder for the CPU's port pair: it supplies the CPU's 4-bit `inr` input and captures the CPU's 16-bit `outvalue` output.
- Input words from the host are queued and presented on `inr` one at a time. Each word is consumed when the CPU executes an input instruction, signalled by `cpu_in_strobe`.
- Every change on `outvalue` is recorded into an output FIFO that the host drains through a valid/ready handshake.
- Sits between the CPU top and the board/testbench host.

Parameters:
- IN_DEPTH, 4, input FIFO entries (power of 2, ≥2).
- OUT_DEPTH, 8, output FIFO entries (power of 2, ≥2).
- INR_W, 4, width of `inr`.
- OUT_W, 16, width of `outvalue`.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- host_in_data  in  INR_W  word to queue for the CPU.
- host_in_valid  in  1  host offers `host_in_data`.
- host_in_ready  out  1  input FIFO not full.
- inr  out  INR_W  value presented to the CPU.
- inr_valid  out  1  `inr` holds an unconsumed queued word.
- cpu_in_strobe  in  1  one-cycle pulse: the CPU consumed `inr`.
- outvalue  in  OUT_W  CPU output value.
- host_out_data  out  OUT_W  oldest captured output value.
- host_out_valid  out  1  output FIFO not empty.
- host_out_ready  in  1  host accepts `host_out_data`.
- clear_status  in  1  synchronous clear of the status outputs.
- in_underflow  out  1  sticky: strobe arrived while `inr_valid` was 0.
- out_overflow  out  1  sticky: a change was dropped because the output FIFO was full.
- drop_count  out  8  number of dropped changes, saturating at 255.

Behaviour:
- Reset (`reset`=0, asynchronous):
  - both FIFOs empty; `inr`=0, `inr_valid`=0.
  - `host_in_ready`=1, `host_out_valid`=0, `host_out_data`=0.
  - `prev_out`=0; sticky flags=0; `drop_count`=0.
- Reset asserted mid-operation discards all queued data immediately; no partial state survives.

Input path:
- Push when `host_in_valid` && `host_in_ready`. `host_in_ready` = !in_full.
- `inr` and `inr_valid` are registered. A word pushed into an empty FIFO appears on `inr` with `inr_valid`=1 one cycle after the push edge.
- `cpu_in_strobe` with `inr_valid`=1 pops the head. On the next cycle `inr` shows the next entry, or, if the FIFO is now empty, holds the popped value with `inr_valid`=0.
- `cpu_in_strobe` with `inr_valid`=0: no pop, `in_underflow` sets, `inr` unchanged.
  - This applies even if a push happens in the same cycle; the pushed word is still queued normally.
- Push and pop in the same cycle on a non-empty FIFO: both take effect and occupancy is unchanged.

Output path:
- `prev_out` register samples `outvalue` every cycle.
- `change` = (`outvalue` != `prev_out`). Because `prev_out` resets to 0, the first nonzero value after reset counts as a change.
- On `change`, `outvalue` is pushed. Capture latency: the value is on `host_out_data` with `host_out_valid`=1 one cycle after the edge that pushed it, if the FIFO was empty.
- Pop when `host_out_valid` && `host_out_ready`. `host_out_data` is the head entry, held stable while valid and not popped.
- `change` while the FIFO is full:
  - If a pop occurs in the same cycle, the push is accepted and nothing is dropped.
  - Otherwise the value is dropped, `out_overflow` sets, and `drop_count` increments (saturating at 255).
- Push and pop on an empty FIFO: the pop is not possible (valid=0), so only the push takes effect.
- FIFO pointers are log2(depth)+1 bits and wrap naturally. Full/empty are determined from the MSB comparison.

Status:
- `clear_status`=1 zeroes `in_underflow`, `out_overflow` and `drop_count` on the next edge.
- If a set event and `clear_status` occur in the same cycle, the set wins: the flag reads 1 and `drop_count` reads 1.

Test Plan:
- Reset, push host words 10, 11, 12, 13 on consecutive cycles → `host_in_ready` drops after the 4th push. `inr`=10 with `inr_valid`=1 one cycle after the first push. Each `cpu_in_strobe` advances `inr` 10→11→12→13. After the 4th strobe, `inr` holds 13 with `inr_valid`=0.
- Strobe on an empty input FIFO → `in_underflow`=1 and `inr` unchanged. Then pulse `clear_status` → `in_underflow`=0.
- Drive `outvalue` 0→5→5→9→9→0 one cycle apart → FIFO captures exactly 5, 9, 0 in order. The host reads these with `host_out_ready`=1, and `host_out_valid` falls after the third read.
- Change `outvalue` on 10 consecutive cycles with `host_out_ready`=0 → 8 entries captured, `out_overflow`=1, `drop_count`=2. The first 8 values read back in order.
- Full output FIFO, then a change coinciding with a host pop → no drop and `drop_count` unchanged. The new value is read last.
- Assert `reset` low mid-stream with both FIFOs partly full → all outputs return immediately to their reset values. After release, a stable `outvalue`=0 produces no capture.
